ysyx_23060171_lsu: RTL and testbench

Load/store unit sitting directly upstream of the data memory stage. It accepts one memory op per handshake from EXU and drives the data memory request port: valid/wen/raddr/waddr/wdata/8-bit wmask. It formats the returned word with byte/half extraction and sign/zero extension, then hands the result to WBU over a valid/ready handshake. A configurable wait counter models memory latency for timing experiments.

---
 rtl/ysyx_23060171_lsu_pkg.sv | 40 ++++
 rtl/ysyx_23060171_lsu_fmt.sv | 63 ++++++
 rtl/ysyx_23060171_lsu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060171_lsu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060171_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
package ysyx_23060171_lsu_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_store;
  } lsu_op_t;

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    case (f3)
      F3_H, F3_HU: misaligned = lo[0];
      F3_W:        misaligned = |lo;
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060171_lsu_fmt.sv
// Load extraction/extension and store lane/mask generation.
// Purely combinational; lane shift is clipped to the access width.
module ysyx_23060171_lsu_fmt
  import ysyx_23060171_lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ldata,
  output logic [XLEN-1:0]   sdata,
  output logic [MASK_W-1:0] smask
);

  logic [1:0]      sh;
  logic [XLEN-1:0] word;

  always_comb begin
    case (funct3)
      F3_H, F3_HU: sh = {lane[1], 1'b0};
      F3_W:        sh = 2'b00;
      default:     sh = lane;
    endcase
  end

  assign word = rdata >> {sh, 3'b000};

  always_comb begin
    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{word[7]}}, word[7:0]};
      F3_BU:   ldata = {24'h0, word[7:0]};
      F3_H:    ldata = {{16{word[15]}}, word[15:0]};
      F3_HU:   ldata = {16'h0, word[15:0]};
      F3_W:    ldata = word;
      default: ldata = '0;
    endcase
  end

  always_comb begin
    sdata = '0;
    smask = '0;
    case (funct3)
      F3_B: begin
        sdata = {4{wdata[7:0]}};
        smask = {4'b0000, 4'b0001 << sh};
      end
      F3_H: begin
        sdata = {2{wdata[15:0]}};
        smask = {4'b0000, 4'b0011 << sh};
      end
      F3_W: begin
        sdata = wdata;
        smask = 8'h0F;
      end
      default: begin
        sdata = '0;
        smask = '0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060171_lsu.sv
// Load/store unit: EXU handshake in, data memory port out, WBU handshake out.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module ysyx_23060171_lsu
  import ysyx_23060171_lsu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_raddr,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e        state;
  lsu_state_e        state_nx;
  lsu_op_t           op_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rdata_q;
  logic              accept;
  logic              is_mem;
  logic              bad;
  logic [XLEN-1:0]   ldata;
  logic [XLEN-1:0]   sdata;
  logic [MASK_W-1:0] smask;
  logic [XLEN-1:0]   waddr;

  assign accept = in_valid && in_ready;
  assign is_mem = in_is_load || in_is_store;

`ifdef LSU_MISALIGN_CHECK_EN
  logic err_q;

  assign bad     = is_mem && misaligned(in_funct3, in_addr[1:0]);
  assign out_err = out_valid && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= bad;
    end
  end
`else
  assign bad     = 1'b0;
  assign out_err = 1'b0;
`endif

  ysyx_23060171_lsu_fmt u_fmt (
    .funct3 (op_q.funct3),
    .lane   (op_q.addr[1:0]),
    .wdata  (op_q.wdata),
    .rdata  (mem_rdata),
    .ldata  (ldata),
    .sdata  (sdata),
    .smask  (smask)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem || bad)    state_nx = S_RESP;
          else if (LATENCY == 0) state_nx = S_ACCESS;
          else                   state_nx = S_WAIT;
        end
      end
      S_WAIT:   if (cnt == '0) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q.addr     <= in_addr;
        op_q.wdata    <= in_wdata;
        op_q.funct3   <= in_funct3;
        op_q.is_load  <= in_is_load;
        op_q.is_store <= in_is_store;
        cnt           <= (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
        // non-memory and trapped ops answer 0
        rdata_q       <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 1'b1;
      end else if (state == S_ACCESS) begin
        rdata_q <= op_q.is_load ? ldata : '0;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign out_rdata = out_valid ? rdata_q : '0;

  assign waddr     = {op_q.addr[XLEN-1:2], 2'b00};
  assign mem_valid = (state == S_ACCESS);
  assign mem_wen   = mem_valid && op_q.is_store;
  assign mem_raddr = mem_valid ? waddr : '0;
  assign mem_waddr = mem_valid ? waddr : '0;
  assign mem_wdata = mem_wen ? sdata : '0;
  assign mem_wmask = mem_wen ? smask : '0;

endmodule

// File: tb/tb_ysyx_23060171_lsu.sv
// Scoreboard bench for the load/store unit.
// Build with LSU_MISALIGN_CHECK_EN to cover the trap path.
module tb_ysyx_23060171_lsu;
  import ysyx_23060171_lsu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_is_load = 1'b0;
  logic        in_is_store = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;

  ysyx_23060171_lsu #(.LATENCY(LAT), .CNT_W(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .in_funct3   (in_funct3),
    .in_is_load  (in_is_load),
    .in_is_store (in_is_store),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_err     (out_err),
    .mem_valid   (mem_valid),
    .mem_wen     (mem_wen),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic ov_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } mem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*lo +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return rd;
      default: return 32'h0;
    endcase
  endfunction

  task automatic st_model(input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] wd,
                          output logic [31:0] sd, output logic [7:0] sm);
    case (f3)
      3'b000: begin sd = {4{wd[7:0]}}; sm = 8'h01 << lo; end
      3'b001: begin sd = {2{wd[15:0]}}; sm = lo[1] ? 8'h0C : 8'h03; end
      3'b010: begin sd = wd; sm = 8'h0F; end
      default: begin sd = 32'h0; sm = 8'h00; end
    endcase
  endtask

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic mis_model(input logic [2:0] f3,
                                     input logic [1:0] lo);
    if (f3 == 3'b001 || f3 == 3'b101) return lo[0];
    if (f3 == 3'b010) return lo != 2'b00;
    return 1'b0;
  endfunction
`endif

  always @(negedge clk) begin
    mem_t m;
    rsp_t r;
    if (!rst) begin
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexp", {31'h0, mem_valid}, 32'h0);
        end else begin
          m = mem_q.pop_front();
          chk("mem_wen", {31'h0, mem_wen}, {31'h0, m.wen});
          chk("mem_raddr", mem_raddr, m.addr);
          chk("mem_waddr", mem_waddr, m.addr);
          chk("mem_wmask", {24'h0, mem_wmask}, {24'h0, m.wmask});
          if (m.wen) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (out_valid && !ov_q && rsp_q.size() > 0)
        chk("latency", cyc - acc_cyc, rsp_q[0].lat);
      if (out_valid && out_ready) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexp", {31'h0, out_valid}, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          chk("out_rdata", out_rdata, r.rdata);
          chk("out_err", {31'h0, out_err}, {31'h0, r.err});
        end
      end
    end
    ov_q = out_valid;
  end

  task automatic op(input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] f3, input logic ld, input logic st,
                    input logic [31:0] rd, input int hold);
    mem_t m;
    rsp_t r;
    logic bad;
    logic [31:0] sd;
    logic [7:0] sm;
    logic [31:0] held;
    int n;
    bad = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    bad = (ld || st) && mis_model(f3, a[1:0]);
`endif
    st_model(f3, a[1:0], wd, sd, sm);
    r.err   = bad;
    r.rdata = (ld && !bad) ? ld_model(f3, a[1:0], rd) : 32'h0;
    r.lat   = ((ld || st) && !bad) ? LAT + 2 : 1;
    if ((ld || st) && !bad) begin
      m.wen   = st;
      m.addr  = {a[31:2], 2'b00};
      m.wdata = sd;
      m.wmask = st ? sm : 8'h00;
      mem_q.push_back(m);
    end
    rsp_q.push_back(r);

    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    in_addr     = a;
    in_wdata    = wd;
    in_funct3   = f3;
    in_is_load  = ld;
    in_is_store = st;
    mem_rdata   = rd;
    out_ready   = (hold == 0);
    @(negedge clk);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_addr     = $urandom;
    in_wdata    = $urandom;
    in_funct3   = 3'($urandom_range(0, 7));
    in_is_load  = 1'b0;
    in_is_store = 1'b0;

    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", {31'h0, out_valid}, 32'h1);
    if (out_valid && hold > 0) begin
      held = out_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'h0, out_valid}, 32'h1);
        chk("hold_rdata", out_rdata, held);
        chk("hold_inrdy", {31'h0, in_ready}, 32'h0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rsp_q.size() != 0 || mem_q.size() != 0) begin
      chk("queue_drain", rsp_q.size() + mem_q.size(), 0);
      mem_q.delete();
      rsp_q.delete();
    end
  endtask

  logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("rst_mem_addr", mem_raddr | mem_waddr, 32'h0);
    chk("rst_mem_data", mem_wdata | {24'h0, mem_wmask}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 0);
    op(32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0, 32'h8512_3456, 0);
    op(32'h8000_0003, 32'h0, 3'b100, 1'b1, 1'b0, 32'h8512_3456, 0);
    op(32'h8000_0002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 0);
    op(32'h8000_0002, 32'h0, 3'b001, 1'b1, 1'b0, 32'h8001_1234, 0);
    op(32'h8000_0000, 32'h0, 3'b101, 1'b1, 1'b0, 32'h1234_F00D, 0);
    op(32'h8000_0001, 32'h0000_005A, 3'b000, 1'b0, 1'b1, 32'h0, 0);
    op(32'h8000_0008, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 32'h0, 0);
    op(32'h8000_0010, 32'h0, 3'b000, 1'b0, 1'b0, 32'hCAFE_F00D, 0);
    op(32'h8000_000C, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0BAD_CAFE, 5);
    op(32'h8000_0004, 32'h0, 3'b011, 1'b1, 1'b0, 32'hFFFF_FFFF, 0);
    op(32'h8000_0002, 32'h0, 3'b010, 1'b1, 1'b0, 32'h7654_3210, 0);
    op(32'h8000_0003, 32'hAAAA_5555, 3'b010, 1'b0, 1'b1, 32'h0, 1);

    for (int i = 0; i < 20; i++) begin
      logic st_r;
      int k;
      logic [2:0] f3;
      st_r = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 4);
      f3 = st_r ? 3'(k % 3) : lf[k];
      op($urandom, $urandom, f3, !st_r, st_r, $urandom,
         $urandom_range(0, 2));
    end

    // reset while the op sits in WAIT
    @(posedge clk);
    #1;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_addr     = 32'h8000_0020;
    in_funct3   = 3'b010;
    in_is_load  = 1'b1;
    in_is_store = 1'b0;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    chk("wait_inrdy", {31'h0, in_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mrst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("mrst_mem_addr", mem_raddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_mem", {31'h0, mem_valid}, 32'h0);
      chk("post_rst_out", {31'h0, out_valid}, 32'h0);
    end

    op(32'h8000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 32'h1357_9BDF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
